// File: rtl/fp_seq_multiplier_pkg.sv
// Shared types and field helpers for the iterative floating-point multiplier.
// Helpers work on a 64-bit container so one definition serves every EXP_W/MAN_W.
package fp_pkg;

  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND} state_e;
  typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} cls_e;

  localparam int FLD_W = 64;
  typedef logic [FLD_W-1:0] fld_t;

  function automatic fld_t fld_frac(input fld_t w, input int man_w);
    return w & ((fld_t'(1) << man_w) - fld_t'(1));
  endfunction

  function automatic fld_t fld_exp(input fld_t w, input int exp_w, input int man_w);
    return (w >> man_w) & ((fld_t'(1) << exp_w) - fld_t'(1));
  endfunction

  function automatic logic fld_sign(input fld_t w, input int exp_w, input int man_w);
    fld_t t;
    t = w >> (exp_w + man_w);
    return t[0];
  endfunction

  function automatic fld_t qnan_word(input int exp_w, input int man_w);
    return (((fld_t'(1) << exp_w) - fld_t'(1)) << man_w) | (fld_t'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_seq_multiplier_if.sv
// Start/done handshake bundle between a requester and the sequential multiplier.
interface fp_seq_multiplier_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int N = 1 + EXP_W + MAN_W;

  logic         en;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] c;
  logic         overflow;
  logic         underflow;
  logic         invalid;

  modport master (output en, start, a, b,
                  input  busy, done, c, overflow, underflow, invalid);
  modport slave  (input  en, start, a, b,
                  output busy, done, c, overflow, underflow, invalid);
endinterface

// File: rtl/fp_seq_multiplier_classify.sv
// Combinational operand decode: class, sign, biased exponent, significand with hidden bit.
// Subnormals are folded into ZERO since the multiplier never handles them.
module fp_classify import fp_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] word,
  output cls_e                 cls,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig
);
  fld_t             wide;
  logic [MAN_W-1:0] frac;

  assign wide = fld_t'(word);
  assign sign = fld_sign(wide, EXP_W, MAN_W);
  assign exp  = EXP_W'(fld_exp(wide, EXP_W, MAN_W));
  assign frac = MAN_W'(fld_frac(wide, MAN_W));

  always_comb begin
    cls = CLS_NORMAL;
    sig = {1'b1, frac};
    if (exp == '0) begin
      cls = CLS_ZERO;
      sig = '0;
    end else if (exp == '1) begin
      cls = (frac != '0) ? CLS_NAN : CLS_INF;
      sig = '0;
    end
  end
endmodule

// File: rtl/fp_seq_multiplier.sv
// Iterative floating-point multiplier: radix-2 shift-add significand product,
// round-to-nearest-even, fixed latency for every operand class.
module fp_seq_multiplier import fp_pkg::*; #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic              clk,
  input logic              rst,
  fp_seq_multiplier_if.slave bus
);
  localparam int N      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int CNT_W  = $clog2(MAN_W + 2);
  localparam int XE_W   = EXP_W + 2;
  localparam logic signed [XE_W-1:0] BIAS    = XE_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [XE_W-1:0] EXP_MAX = XE_W'((2 ** EXP_W) - 1);
  localparam logic [N-1:0]           QNAN    = N'(qnan_word(EXP_W, MAN_W));
  localparam logic [CNT_W-1:0]       LAST    = CNT_W'(MAN_W);

  state_e                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    busy_r, done_r, ovf_r, unf_r, inv_r;
  logic [N-1:0]            c_r;

  logic [N-1:0]            a_q, b_q;
  logic                    sign_q;
  logic signed [XE_W-1:0]  exp_q;
  cls_e                    rcls_q;
  logic [SIG_W-1:0]        mcand_q;
  logic [PROD_W-1:0]       acc_q;
  logic [MAN_W-1:0]        frac_q;
  logic                    guard_q, sticky_q;

  cls_e                    cls_a, cls_b;
  logic                    sign_a, sign_b;
  logic [EXP_W-1:0]        exp_a, exp_b;
  logic [SIG_W-1:0]        sig_a, sig_b;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .word(a_q), .cls(cls_a), .sign(sign_a), .exp(exp_a), .sig(sig_a));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .word(b_q), .cls(cls_b), .sign(sign_b), .exp(exp_b), .sig(sig_b));

  function automatic cls_e resolve(input cls_e ca, input cls_e cb);
    if (ca == CLS_NAN || cb == CLS_NAN ||
        (ca == CLS_ZERO && cb == CLS_INF) || (ca == CLS_INF && cb == CLS_ZERO))
      return CLS_NAN;
    if (ca == CLS_INF || cb == CLS_INF)   return CLS_INF;
    if (ca == CLS_ZERO || cb == CLS_ZERO) return CLS_ZERO;
    return CLS_NORMAL;
  endfunction

  // Returns {overflow, underflow, word}; a rounding carry bumps the exponent.
  function automatic logic [N+1:0] round_pack(input logic sgn, input logic signed [XE_W-1:0] e_in,
                                              input logic [MAN_W-1:0] frac, input logic guard,
                                              input logic sticky);
    logic                   up;
    logic [MAN_W:0]         sum;
    logic signed [XE_W-1:0] e;
    up  = guard & (sticky | frac[0]);
    sum = {1'b0, frac} + {{MAN_W{1'b0}}, up};
    e   = e_in + $signed({{(XE_W-1){1'b0}}, sum[MAN_W]});
    if (e >= EXP_MAX)
      return {2'b10, sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    if (e[XE_W-1] || e == '0)
      return {2'b01, sgn, {(EXP_W+MAN_W){1'b0}}};
    return {2'b00, sgn, e[EXP_W-1:0], sum[MAN_W-1:0]};
  endfunction

  logic signed [XE_W-1:0] exp_sum;
  logic [SIG_W:0]         add_sum;
  logic                   norm_top, norm_guard, norm_sticky;
  logic [MAN_W-1:0]       norm_frac;
  logic [N+1:0]           rnd;
  logic [N-1:0]           res_word;
  logic                   res_ovf, res_unf, res_inv;

  assign exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;
  assign add_sum = {1'b0, acc_q[PROD_W-1:SIG_W]} + {1'b0, (acc_q[0] ? mcand_q : {SIG_W{1'b0}})};
  assign rnd     = round_pack(sign_q, exp_q, frac_q, guard_q, sticky_q);

  always_comb begin
    norm_top = acc_q[PROD_W-1];
    if (norm_top) begin
      norm_frac   = acc_q[2*MAN_W:MAN_W+1];
      norm_guard  = acc_q[MAN_W];
      norm_sticky = |acc_q[MAN_W-1:0];
    end else begin
      norm_frac   = acc_q[2*MAN_W-1:MAN_W];
      norm_guard  = acc_q[MAN_W-1];
      norm_sticky = |acc_q[MAN_W-2:0];
    end
  end

  always_comb begin
    res_word = rnd[N-1:0];
    res_ovf  = rnd[N+1];
    res_unf  = rnd[N];
    res_inv  = 1'b0;
    case (rcls_q)
      CLS_NAN:  begin res_word = QNAN; res_ovf = 1'b0; res_unf = 1'b0; res_inv = 1'b1; end
      CLS_INF:  begin res_word = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}; res_ovf = 1'b0; res_unf = 1'b0; end
      CLS_ZERO: begin res_word = {sign_q, {(EXP_W+MAN_W){1'b0}}}; res_ovf = 1'b0; res_unf = 1'b0; end
      default:  ;
    endcase
  end

  // Datapath registers: no reset, only meaningful while the FSM walks an operation.
  always_ff @(posedge clk) begin
    if (bus.en) begin
      case (state)
        S_IDLE: if (bus.start) begin
          a_q <= bus.a;
          b_q <= bus.b;
        end
        S_UNPACK: begin
          sign_q  <= sign_a ^ sign_b;
          exp_q   <= exp_sum;
          rcls_q  <= resolve(cls_a, cls_b);
          mcand_q <= sig_a;
          acc_q   <= {{SIG_W{1'b0}}, sig_b};
        end
        S_MULT: acc_q <= {add_sum, acc_q[SIG_W-1:1]};
        S_NORM: begin
          frac_q   <= norm_frac;
          guard_q  <= norm_guard;
          sticky_q <= norm_sticky;
          exp_q    <= exp_q + $signed({{(XE_W-1){1'b0}}, norm_top});
        end
        default: ;
      endcase
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      ovf_r  <= 1'b0;
      unf_r  <= 1'b0;
      inv_r  <= 1'b0;
      c_r    <= '0;
    end else if (bus.en) begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: if (bus.start) begin
          state  <= S_UNPACK;
          busy_r <= 1'b1;
          cnt    <= '0;
          ovf_r  <= 1'b0;
          unf_r  <= 1'b0;
          inv_r  <= 1'b0;
        end
        S_UNPACK: state <= S_MULT;
        S_MULT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= S_NORM;
        end
        S_NORM: state <= S_ROUND;
        S_ROUND: begin
          state  <= S_IDLE;
          c_r    <= res_word;
          ovf_r  <= res_ovf;
          unf_r  <= res_unf;
          inv_r  <= res_inv;
          done_r <= 1'b1;
          busy_r <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.c         = c_r;
  assign bus.overflow  = ovf_r;
  assign bus.underflow = unf_r;
  assign bus.invalid   = inv_r;
endmodule
